// File: rtl/ara_pkg.sv
// Shared Ara definitions used by the cluster response join.
//   MaxNrClusters        : upper bound on the number of Ara instances
//   ELEN                 : scalar element width
//   RespJoinIdWidth      : default transaction-id width
//   RespJoinDefaultDepth : default per-cluster response buffer depth
//   resp_join_entry_t    : one buffered cluster response {result, id, exc}
package ara_pkg;

    localparam int unsigned MaxNrClusters        = 8;
    localparam int unsigned ELEN                 = 64;
    localparam int unsigned RespJoinIdWidth      = 4;
    localparam int unsigned RespJoinDefaultDepth = 2;

    typedef struct packed {
        logic [ELEN-1:0]            result;
        logic [RespJoinIdWidth-1:0] id;
        logic                       exc;
    } resp_join_entry_t;

    // Index width for a vector of n items; never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ara_resp_join_fifo.sv
// Single-cluster response buffer with registered ready and empty flags.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   push_valid_i   : cluster response valid
//   push_ready_o   : buffer has room (registered, 0 while in reset)
//   push_data_i    : response entry to store
//   pop_i          : remove the head entry (ignored when empty)
//   empty_o        : buffer holds no entry (registered)
//   head_o         : oldest stored entry
module ara_resp_join_fifo
    import ara_pkg::*;
#(
    parameter int unsigned Depth   = RespJoinDefaultDepth,
    parameter type         entry_t = resp_join_entry_t
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   push_valid_i,
    output logic   push_ready_o,
    input  entry_t push_data_i,
    input  logic   pop_i,
    output logic   empty_o,
    output entry_t head_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    entry_t                mem_q [Depth];
    logic [PtrWidth-1:0]   wr_ptr_q;
    logic [PtrWidth-1:0]   rd_ptr_q;
    logic [CntWidth-1:0]   cnt_q;
    logic [CntWidth-1:0]   cnt_d;
    logic                  ready_q;
    logic                  empty_q;
    logic                  push;
    logic                  pop;

    assign push = push_valid_i & ready_q;
    assign pop  = pop_i & ~empty_q;

    // Occupancy after this cycle's push/pop; push+pop together leaves it unchanged.
    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntWidth'(1);
            2'b01:   cnt_d = cnt_q - CntWidth'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage, pointers and flags; pointers wrap naturally since Depth is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PtrWidth'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
            end
            cnt_q   <= cnt_d;
            ready_q <= (cnt_d != CntWidth'(Depth));
            empty_q <= (cnt_d == '0);
        end
    end

    assign push_ready_o = ready_q;
    assign empty_o      = empty_q;
    assign head_o       = mem_q[rd_ptr_q];

endmodule

// File: rtl/ara_resp_join.sv
// Joins per-cluster Ara responses into one merged response towards CVA6.
// Each cluster stream is buffered separately; a merged response is offered
// once every cluster holds a response, and all heads pop together.
// Ports:
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   clu_valid_i/ready_o   : per-cluster response handshake
//   clu_result_i/id_i/exc_i : per-cluster response payload (flattened)
//   resp_valid_o/ready_i  : merged response handshake
//   resp_result_o/id_o    : cluster 0 head result and id
//   resp_exc_o            : OR of head exception flags
//   resp_exc_cluster_o    : lowest cluster index with exception set
//   id_mismatch_o         : sticky flag, head ids disagreed at a pop
// Optional build macro ARA_RESP_JOIN_PERF_EN adds:
//   perf_skew_cycles_o         : cycles with some buffers empty and some not
//   perf_backpressure_cycles_o : cycles with resp_valid_o && !resp_ready_i
module ara_resp_join
    import ara_pkg::*;
#(
    parameter  int unsigned NrClusters  = 4,
    parameter  int unsigned DataWidth   = ELEN,
    parameter  int unsigned IdWidth     = RespJoinIdWidth,
    parameter  int unsigned Depth       = RespJoinDefaultDepth,
    localparam int unsigned ExcIdxWidth = clog2_min1(NrClusters)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NrClusters-1:0]           clu_valid_i,
    output logic [NrClusters-1:0]           clu_ready_o,
    input  logic [NrClusters*DataWidth-1:0] clu_result_i,
    input  logic [NrClusters*IdWidth-1:0]   clu_id_i,
    input  logic [NrClusters-1:0]           clu_exc_i,
    output logic                            resp_valid_o,
    input  logic                            resp_ready_i,
    output logic [DataWidth-1:0]            resp_result_o,
    output logic [IdWidth-1:0]              resp_id_o,
    output logic                            resp_exc_o,
    output logic [ExcIdxWidth-1:0]          resp_exc_cluster_o,
    output logic                            id_mismatch_o
`ifdef ARA_RESP_JOIN_PERF_EN
    ,
    output logic [31:0]                     perf_skew_cycles_o,
    output logic [31:0]                     perf_backpressure_cycles_o
`endif
);

    typedef struct packed {
        logic [DataWidth-1:0] result;
        logic [IdWidth-1:0]   id;
        logic                 exc;
    } entry_t;

    entry_t                push_data [NrClusters];
    entry_t                head      [NrClusters];
    logic [NrClusters-1:0] empty;
    logic                  pop;
    logic                  id_diff;
    logic                  id_mismatch_q;

    // One buffer per cluster.
    for (genvar c = 0; c < NrClusters; c++) begin : g_clu
        assign push_data[c].result = clu_result_i[c*DataWidth +: DataWidth];
        assign push_data[c].id     = clu_id_i[c*IdWidth +: IdWidth];
        assign push_data[c].exc    = clu_exc_i[c];

        ara_resp_join_fifo #(
            .Depth   (Depth),
            .entry_t (entry_t)
        ) i_fifo (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .push_valid_i (clu_valid_i[c]),
            .push_ready_o (clu_ready_o[c]),
            .push_data_i  (push_data[c]),
            .pop_i        (pop),
            .empty_o      (empty[c]),
            .head_o       (head[c])
        );
    end

    // Valid comes only from registered empty flags, so it cannot glitch on clu_valid_i.
    assign resp_valid_o = &(~empty);
    assign pop          = resp_valid_o & resp_ready_i;

    // Merge the heads: cluster 0 supplies result/id, exceptions are OR-ed.
    always_comb begin
        resp_result_o      = head[0].result;
        resp_id_o          = head[0].id;
        resp_exc_o         = 1'b0;
        resp_exc_cluster_o = '0;
        id_diff            = 1'b0;
        for (int unsigned c = 0; c < NrClusters; c++) begin
            if (head[c].exc && !resp_exc_o) begin
                resp_exc_o         = 1'b1;
                resp_exc_cluster_o = ExcIdxWidth'(c);
            end
            if (head[c].id != head[0].id) begin
                id_diff = 1'b1;
            end
        end
    end

    // Sticky protocol error; the merge itself still completes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            id_mismatch_q <= 1'b0;
        end else if (pop && id_diff) begin
            id_mismatch_q <= 1'b1;
        end
    end

    assign id_mismatch_o = id_mismatch_q;

`ifdef ARA_RESP_JOIN_PERF_EN
    logic        skew;
    logic [31:0] skew_cnt_q;
    logic [31:0] bp_cnt_q;

    assign skew = (|empty) & ~(&empty);

    // Saturating event counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            skew_cnt_q <= '0;
            bp_cnt_q   <= '0;
        end else begin
            if (skew && (skew_cnt_q != '1)) begin
                skew_cnt_q <= skew_cnt_q + 32'd1;
            end
            if (resp_valid_o && !resp_ready_i && (bp_cnt_q != '1)) begin
                bp_cnt_q <= bp_cnt_q + 32'd1;
            end
        end
    end

    assign perf_skew_cycles_o         = skew_cnt_q;
    assign perf_backpressure_cycles_o = bp_cnt_q;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ara_resp_join.sv
// Randomized and directed bench for ara_resp_join against a queue-based model.
module tb_ara_resp_join;

    localparam int NC = 4;
    localparam int DW = 64;
    localparam int IW = 4;
    localparam int D  = 2;
    localparam int EW = 2;

    logic                 clk = 1'b0;
    logic                 rst_i;
    logic [NC-1:0]        clu_valid_i;
    logic [NC-1:0]        clu_ready_o;
    logic [NC*DW-1:0]     clu_result_i;
    logic [NC*IW-1:0]     clu_id_i;
    logic [NC-1:0]        clu_exc_i;
    logic                 resp_valid_o;
    logic                 resp_ready_i;
    logic [DW-1:0]        resp_result_o;
    logic [IW-1:0]        resp_id_o;
    logic                 resp_exc_o;
    logic [EW-1:0]        resp_exc_cluster_o;
    logic                 id_mismatch_o;
`ifdef ARA_RESP_JOIN_PERF_EN
    logic [31:0]          perf_skew_cycles_o;
    logic [31:0]          perf_backpressure_cycles_o;
`endif

    always #5 clk = ~clk;

    ara_resp_join #(
        .NrClusters (NC),
        .DataWidth  (DW),
        .IdWidth    (IW),
        .Depth      (D)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .clu_valid_i        (clu_valid_i),
        .clu_ready_o        (clu_ready_o),
        .clu_result_i       (clu_result_i),
        .clu_id_i           (clu_id_i),
        .clu_exc_i          (clu_exc_i),
        .resp_valid_o       (resp_valid_o),
        .resp_ready_i       (resp_ready_i),
        .resp_result_o      (resp_result_o),
        .resp_id_o          (resp_id_o),
        .resp_exc_o         (resp_exc_o),
        .resp_exc_cluster_o (resp_exc_cluster_o),
        .id_mismatch_o      (id_mismatch_o)
`ifdef ARA_RESP_JOIN_PERF_EN
        ,
        .perf_skew_cycles_o         (perf_skew_cycles_o),
        .perf_backpressure_cycles_o (perf_backpressure_cycles_o)
`endif
    );

    typedef struct packed {
        logic [DW-1:0] r;
        logic [IW-1:0] id;
        logic          exc;
    } ent_t;

    // Reference model: one queue per cluster plus sticky/perf bookkeeping.
    ent_t          mq [NC][$];
    logic          mm_m;
    int unsigned   skew_m;
    int unsigned   bp_m;
    int unsigned   pushed_cnt [NC];

    logic [DW-1:0] drv_res [NC];
    logic [IW-1:0] drv_id  [NC];
    logic          drv_exc [NC];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare();
        logic [NC-1:0] er;
        logic          all_ne;
        logic          ex;
        logic [EW-1:0] ec;
        all_ne = 1'b1;
        ex     = 1'b0;
        ec     = '0;
        for (int c = 0; c < NC; c++) begin
            er[c] = (mq[c].size() < D);
            if (mq[c].size() == 0) all_ne = 1'b0;
        end
        check("clu_ready", 64'(clu_ready_o), 64'(er));
        check("resp_valid", 64'(resp_valid_o), 64'(all_ne));
        if (all_ne) begin
            for (int c = NC - 1; c >= 0; c--) begin
                if (mq[c][0].exc) begin
                    ex = 1'b1;
                    ec = EW'(c);
                end
            end
            check("resp_result", 64'(resp_result_o), 64'(mq[0][0].r));
            check("resp_id", 64'(resp_id_o), 64'(mq[0][0].id));
            check("resp_exc", 64'(resp_exc_o), 64'(ex));
            check("resp_exc_cluster", 64'(resp_exc_cluster_o), 64'(ec));
        end
        check("id_mismatch", 64'(id_mismatch_o), 64'(mm_m));
`ifdef ARA_RESP_JOIN_PERF_EN
        check("perf_skew", 64'(perf_skew_cycles_o), 64'(skew_m));
        check("perf_backpressure", 64'(perf_backpressure_cycles_o), 64'(bp_m));
`endif
    endtask

    // One clock: check outputs, drive inputs for the coming edge, advance the model.
    task automatic step(input logic [NC-1:0] v, input logic rdy);
        int   sz [NC];
        logic all_ne;
        logic any_ne;
        ent_t e;
        @(negedge clk);
        compare();
        for (int c = 0; c < NC; c++) begin
            clu_valid_i[c]             = v[c];
            clu_result_i[c*DW +: DW]   = drv_res[c];
            clu_id_i[c*IW +: IW]       = drv_id[c];
            clu_exc_i[c]               = drv_exc[c];
        end
        resp_ready_i = rdy;
        all_ne = 1'b1;
        any_ne = 1'b0;
        for (int c = 0; c < NC; c++) begin
            sz[c] = mq[c].size();
            if (sz[c] == 0) all_ne = 1'b0;
            else            any_ne = 1'b1;
        end
        if (any_ne && !all_ne) skew_m++;
        if (all_ne && !rdy)    bp_m++;
        if (all_ne && rdy) begin
            for (int c = 1; c < NC; c++) begin
                if (mq[c][0].id != mq[0][0].id) mm_m = 1'b1;
            end
            for (int c = 0; c < NC; c++) void'(mq[c].pop_front());
        end
        for (int c = 0; c < NC; c++) begin
            if (v[c] && sz[c] < D) begin
                e.r   = drv_res[c];
                e.id  = drv_id[c];
                e.exc = drv_exc[c];
                mq[c].push_back(e);
                pushed_cnt[c]++;
            end
        end
    endtask

    task automatic clear_model();
        for (int c = 0; c < NC; c++) begin
            mq[c].delete();
            pushed_cnt[c] = 0;
        end
        mm_m   = 1'b0;
        skew_m = 0;
        bp_m   = 0;
    endtask

    task automatic set_all(input logic [DW-1:0] r, input logic [IW-1:0] id, input logic exc);
        for (int c = 0; c < NC; c++) begin
            drv_res[c] = r;
            drv_id[c]  = id;
            drv_exc[c] = exc;
        end
    endtask

    task automatic do_reset();
        rst_i        = 1'b1;
        clu_valid_i  = '0;
        resp_ready_i = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(clu_ready_o), 64'(0));
        check("rst_valid", 64'(resp_valid_o), 64'(0));
        check("rst_result", 64'(resp_result_o), 64'(0));
        check("rst_mismatch", 64'(id_mismatch_o), 64'(0));
        @(negedge clk);
        rst_i = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        clu_valid_i  = '0;
        clu_result_i = '0;
        clu_id_i     = '0;
        clu_exc_i    = '0;
        resp_ready_i = 1'b0;
        set_all('0, '0, 1'b0);
        do_reset();

        // Staggered arrival, one merged response.
        set_all(64'h1234, 4'd3, 1'b0);
        drv_res[0] = 64'hA5;
        for (int cyc = 0; cyc < 12; cyc++) begin
            case (cyc)
                0:       step(4'b0001, 1'b1);
                2:       step(4'b0010, 1'b1);
                5:       step(4'b0100, 1'b1);
                7:       step(4'b1000, 1'b1);
                default: step(4'b0000, 1'b1);
            endcase
        end

        // Exceptions from clusters 1 and 3.
        set_all(64'h77, 4'd9, 1'b0);
        drv_exc[1] = 1'b1;
        drv_exc[3] = 1'b1;
        step(4'b1111, 1'b1);
        set_all('0, '0, 1'b0);
        repeat (3) step(4'b0000, 1'b1);

        // Backpressure fills cluster 0, then drains in order.
        for (int i = 0; i < 3; i++) begin
            drv_id[0]  = IW'(i);
            drv_res[0] = 64'(100 + i);
            step(4'b0001, 1'b0);
        end
        step(4'b0000, 1'b0);
        for (int i = 0; i < 2; i++) begin
            set_all(64'(200 + i), IW'(i), 1'b0);
            drv_res[0] = 64'(100 + i);
            step(4'b1110, 1'b0);
        end
        repeat (4) step(4'b0000, 1'b1);

        // Id mismatch on cluster 2; flag holds through later matching traffic.
        set_all(64'h44, 4'd4, 1'b0);
        drv_id[2] = 4'd5;
        step(4'b1111, 1'b1);
        for (int i = 0; i < 3; i++) begin
            set_all(64'(i), 4'd6, 1'b0);
            step(4'b1111, 1'b1);
        end
        repeat (3) step(4'b0000, 1'b1);

        // Asynchronous reset with full buffers.
        set_all(64'h55, 4'd1, 1'b0);
        step(4'b1111, 1'b0);
        step(4'b1111, 1'b0);
        step(4'b0000, 1'b0);
        @(posedge clk);
        #2;
        rst_i = 1'b1;
        #1;
        check("async_rst_valid", 64'(resp_valid_o), 64'(0));
        check("async_rst_mismatch", 64'(id_mismatch_o), 64'(0));
        check("async_rst_ready", 64'(clu_ready_o), 64'(0));
        clear_model();
        clu_valid_i = '0;
        @(negedge clk);
        rst_i = 1'b0;
        repeat (2) @(posedge clk);
        repeat (4) step(4'b0000, 1'b1);

        // Skew and backpressure scenario.
        set_all(64'h99, 4'd2, 1'b0);
        step(4'b0001, 1'b0);
        repeat (5) step(4'b0000, 1'b0);
        step(4'b1110, 1'b0);
        repeat (3) step(4'b0000, 1'b0);
        repeat (3) step(4'b0000, 1'b1);

        // Randomized traffic.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            logic [NC-1:0] v;
            v = NC'($urandom);
            for (int c = 0; c < NC; c++) begin
                drv_res[c] = {32'($urandom), 32'($urandom)};
                drv_id[c]  = IW'(pushed_cnt[c]) ^ IW'(($urandom_range(0, 63) == 0) ? 1 : 0);
                drv_exc[c] = ($urandom_range(0, 7) == 0);
            end
            step(v, ($urandom_range(0, 3) != 0));
        end
        repeat (6) step(4'b0000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
